pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. Drives the load and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, taken-branch squashes, multi-cycle multiply occupancy of EX, and external memory stalls. It also keeps a saturating stall-cycle counter for performance statistics.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_detect.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Sequencer states: normal flow, or EX occupied by a multi-cycle multiply.
  typedef enum logic [0:0] {
    RUN       = 1'b0,
    MULT_WAIT = 1'b1
  } state_t;

  // Width of the multiply occupancy counter (MULT_LATENCY up to 15).
  localparam int MULT_CNT_WIDTH = 4;

  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load
// in EX is about to write.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      hazard
);

  logic rd_nonzero;
  logic rs_match;
  logic rt_match;

  // A match only matters for sources the ID instruction actually reads.
  always_comb begin
    rd_nonzero = (ex_rd != REG_ADDR_WIDTH'(REG_ZERO));
    rs_match   = id_uses_rs && (id_rs == ex_rd);
    rt_match   = id_uses_rt && (id_rt == ex_rd);
    hazard     = ex_mem_read && rd_nonzero && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// squashes, multiply occupancy of EX, memory freezes and a stall counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MULT_LATENCY   = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ext_stall,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_mult,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_branch_taken,
  input  logic                      clr_stats,
  output logic                      pc_ld,
  output logic                      if_id_ld,
  output logic                      id_ex_ld,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      mult_busy,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output state_t                    fsm_state
);

  state_t                    state_q;
  state_t                    state_d;
  logic [MULT_CNT_WIDTH-1:0] cnt_q;
  logic [MULT_CNT_WIDTH-1:0] cnt_d;
  logic                      hazard;

  hazard_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  assign mult_busy = (state_q == MULT_WAIT);
  assign fsm_state = state_q;

  // State and occupancy counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and pipeline control; reset and memory freeze override the FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_ld        = 1'b0;
    if_id_ld     = 1'b0;
    id_ex_ld     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (rst || ext_stall) begin
      // Everything frozen; state and cnt hold (reset is applied by the register).
    end else begin
      unique case (state_q)
        RUN: begin
          pc_ld    = 1'b1;
          if_id_ld = 1'b1;
          id_ex_ld = 1'b1;
          if (ex_branch_taken) begin
            // Squash the two younger instructions; ID's multiply is discarded.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hazard) begin
            // Hold PC and IF/ID, send a bubble into EX for one cycle.
            pc_ld       = 1'b0;
            if_id_ld    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_mult) begin
            state_d = MULT_WAIT;
            cnt_d   = MULT_CNT_WIDTH'(MULT_LATENCY);
          end
        end
        MULT_WAIT: begin
          if (cnt_q > MULT_CNT_WIDTH'(1)) begin
            // Multiply still in EX: freeze the front, keep bubbling into MEM.
            ex_mem_flush = 1'b1;
            cnt_d        = cnt_q - MULT_CNT_WIDTH'(1);
          end else begin
            pc_ld    = 1'b1;
            if_id_ld = 1'b1;
            id_ex_ld = 1'b1;
            state_d  = RUN;
            cnt_d    = '0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating count of non-reset cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (clr_stats) begin
      stall_cycles <= '0;
    end else if (!pc_ld && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

endmodule
